// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue controller: operand width, opcode and queued request entry.
package alu_issue_pkg;

  localparam int W = 4;

  typedef logic [1:0] op_t;

  typedef struct packed {
    op_t          op;
    logic [W-1:0] b;
    logic [W-1:0] a;
  } alu_req_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request and response handshakes of the ALU issue controller.
interface alu_issue_ctrl_if
  import alu_issue_pkg::*;
#(
  parameter int SEQ_W = 4
);

  logic             req_valid;
  logic             req_ready;
  logic [W-1:0]     req_a;
  logic [W-1:0]     req_b;
  op_t              req_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_f;
  op_t              rsp_op;
  logic [SEQ_W-1:0] rsp_seq;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_f, rsp_op, rsp_seq
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_f, rsp_op, rsp_seq
  );

endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous FIFO of request entries; head reads as zero when empty.
module alu_req_fifo
  import alu_issue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = alu_req_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  entry_t                     din,
  input  logic                       pop,
  output entry_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is flushed logically by the pointers, so the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Queues ALU requests, drives the external alu_4bit from the queue head and registers its result.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int SEQ_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  alu_issue_ctrl_if.slave            bus,
  output logic [W-1:0]               alu_a,
  output logic [W-1:0]               alu_b,
  output op_t                        alu_op,
  input  logic [W-1:0]               alu_f,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  alu_req_t         req_p0;
  alu_req_t         head_p0;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push_p0;
  logic             issue_p0;

  logic             rsp_vld_p1;
  logic [W-1:0]     rsp_f_p1;
  op_t              rsp_op_p1;
  logic [SEQ_W-1:0] rsp_seq_p1;
  logic [SEQ_W-1:0] seq_cnt;

  assign req_p0   = '{op: bus.req_op, b: bus.req_b, a: bus.req_a};
  assign push_p0  = bus.req_valid && !fifo_full;
  assign issue_p0 = !fifo_empty && (!rsp_vld_p1 || bus.rsp_ready);

  alu_req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (alu_req_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_p0),
    .din   (req_p0),
    .pop   (issue_p0),
    .head  (head_p0),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.req_ready = !fifo_full;
  assign alu_a         = head_p0.a;
  assign alu_b         = head_p0.b;
  assign alu_op        = head_p0.op;

  // Stage p0 -> p1: capture the ALU result for the head entry into the response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p1 <= 1'b0;
      rsp_f_p1   <= '0;
      rsp_op_p1  <= '0;
      rsp_seq_p1 <= '0;
      seq_cnt    <= '0;
    end else if (issue_p0) begin
      rsp_vld_p1 <= 1'b1;
      rsp_f_p1   <= alu_f;
      rsp_op_p1  <= head_p0.op;
      rsp_seq_p1 <= seq_cnt;
      seq_cnt    <= seq_cnt + SEQ_W'(1);
    end else if (bus.rsp_ready) begin
      rsp_vld_p1 <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_vld_p1;
  assign bus.rsp_f     = rsp_f_p1;
  assign bus.rsp_op    = rsp_op_p1;
  assign bus.rsp_seq   = rsp_seq_p1;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a stand-in combinational ALU.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int DEPTH = 4;
  localparam int SEQ_W = 4;
  localparam int CW    = $clog2(DEPTH+1);

  typedef struct {
    int f;
    int op;
    int seq;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.SEQ_W(SEQ_W)) bus ();

  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  op_t           alu_op;
  logic [W-1:0]  alu_f;
  logic [CW-1:0] fifo_count;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  int model_seq = 0;

  function automatic int ref_alu(int a, int b, int op);
    case (op)
      0:       return (a + b) % 16;
      1:       return (a - b + 16) % 16;
      2:       return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_f = W'(ref_alu(int'(alu_a), int'(alu_b), int'(alu_op)));

  alu_issue_ctrl #(.W(W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_f      (alu_f),
    .fifo_count (fifo_count)
  );

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: records accepted requests and checks consumed responses in order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        model_seq = 0;
      end else begin
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rsp_f", int'(bus.rsp_f), e.f);
            check("rsp_op", int'(bus.rsp_op), e.op);
            check("rsp_seq", int'(bus.rsp_seq), e.seq);
          end
        end
        if (bus.req_valid && bus.req_ready) begin
          e.f   = ref_alu(int'(bus.req_a), int'(bus.req_b), int'(bus.req_op));
          e.op  = int'(bus.req_op);
          e.seq = model_seq % (1 << SEQ_W);
          exp_q.push_back(e);
          model_seq++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(int a, int b, int op);
    int n;
    bus.req_valid = 1'b1;
    bus.req_a     = W'(a);
    bus.req_b     = W'(b);
    bus.req_op    = op_t'(op);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("push_timeout", 0, 1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.rsp_ready = 1'b1;
    n = 0;
    while ((fifo_count != 0 || bus.rsp_valid) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("drain_timeout", 0, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = 1'b1;
    bus.req_a     = 4'd5;
    bus.req_b     = 4'd7;
    bus.req_op    = 2'd2;
    bus.rsp_ready = 1'b0;

    // Reset with a request presented
    tick();
    tick();
    tick();
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_alu_a", int'(alu_a), 0);
    check("rst_alu_b", int'(alu_b), 0);
    check("rst_alu_op", int'(alu_op), 0);
    check("rst_req_ready", int'(bus.req_ready), 1);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("rst_nothing_stored", int'(fifo_count), 0);

    // Single request latency
    bus.rsp_ready = 1'b1;
    push_one(2, 6, 0);
    check("single_alu_a", int'(alu_a), 2);
    check("single_alu_b", int'(alu_b), 6);
    check("single_alu_op", int'(alu_op), 0);
    check("single_count_after_push", int'(fifo_count), 1);
    tick();
    check("single_rsp_valid", int'(bus.rsp_valid), 1);
    check("single_rsp_f", int'(bus.rsp_f), 8);
    check("single_rsp_op", int'(bus.rsp_op), 0);
    check("single_rsp_seq", int'(bus.rsp_seq), 0);
    check("single_count", int'(fifo_count), 0);
    drain();

    // Backpressure and full
    do_reset();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_one(i + 1, 3, i % 4);
    check("full_count", int'(fifo_count), 4);
    check("full_req_ready", int'(bus.req_ready), 0);
    check("full_rsp_valid", int'(bus.rsp_valid), 1);
    check("full_rsp_seq", int'(bus.rsp_seq), 0);
    check("full_rsp_f", int'(bus.rsp_f), 4);
    bus.req_valid = 1'b1;
    bus.req_a     = 4'd9;
    bus.req_b     = 4'd12;
    bus.req_op    = 2'd3;
    tick();
    tick();
    check("full_held_ready", int'(bus.req_ready), 0);
    check("full_held_count", int'(fifo_count), 4);
    bus.rsp_ready = 1'b1;
    push_one(9, 12, 3);
    drain();

    // Simultaneous push and pop
    bus.rsp_ready = 1'b0;
    push_one(7, 2, 1);
    push_one(3, 5, 0);
    push_one(15, 6, 2);
    check("simul_count_before", int'(fifo_count), 2);
    bus.rsp_ready = 1'b1;
    push_one(10, 4, 3);
    check("simul_count_after", int'(fifo_count), 2);
    drain();

    // Sequence wrap over 17 back-to-back requests
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_one($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
    drain();

    // Mid-operation reset
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(i, i + 4, 1);
    check("mid_count", int'(fifo_count), 3);
    check("mid_rsp_valid", int'(bus.rsp_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("mid_rst_count", int'(fifo_count), 0);
    check("mid_rst_rsp_f", int'(bus.rsp_f), 0);
    check("mid_rst_rsp_seq", int'(bus.rsp_seq), 0);
    check("mid_rst_alu_a", int'(alu_a), 0);
    check("mid_rst_alu_b", int'(alu_b), 0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    push_one(2, 1, 1);
    tick();
    check("post_rst_rsp_valid", int'(bus.rsp_valid), 1);
    check("post_rst_rsp_f", int'(bus.rsp_f), 1);
    check("post_rst_rsp_op", int'(bus.rsp_op), 1);
    check("post_rst_rsp_seq", int'(bus.rsp_seq), 0);
    drain();

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.req_valid = ($urandom_range(0, 3) != 0);
      bus.req_a     = W'($urandom_range(0, 15));
      bus.req_b     = W'($urandom_range(0, 15));
      bus.req_op    = op_t'($urandom_range(0, 3));
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    bus.req_valid = 1'b0;
    drain();
    tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Request buffer and issue controller sitting directly upstream of the existing combinational `alu_4bit`. Accepts operand/opcode requests over a valid/ready handshake, queues them in a small FIFO, drives the ALU `a`/`b`/`op` inputs from the queue head, and registers the returned `f` into a response register with its own valid/ready handshake. Decouples producers from consumers of ALU results at one operation per cycle.

## Interface
- `W`, 4: operand/result width; must match `alu_4bit`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `SEQ_W`, 4: width of the response sequence tag.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: FIFO can accept.
- `req_a` in W: operand a.
- `req_b` in W: operand b.
- `req_op` in 2: opcode, passed unmodified to the ALU.
- `alu_a` out W: to `alu_4bit` a.
- `alu_b` out W: to `alu_4bit` b.
- `alu_op` out 2: to `alu_4bit` op.
- `alu_f` in W: from `alu_4bit` f.
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_f` out W: registered ALU result.
- `rsp_op` out 2: opcode that produced `rsp_f`.
- `rsp_seq` out SEQ_W: issue sequence number.
- `fifo_count` out clog2(DEPTH+1): current FIFO occupancy.

## Operation
- Push: `req_valid && req_ready` stores {op,b,a} at the write pointer. `req_ready = (fifo_count != DEPTH)`; it does not depend on `rsp_ready` or a same-cycle pop.
- ALU drive: `alu_a/alu_b/alu_op` are combinational from the FIFO head entry. When the FIFO is empty, all three are 0.
- Issue: fires when FIFO is non-empty and the response register is free (`!rsp_valid || rsp_ready`). On the edge, `rsp_f <= alu_f`, `rsp_op <= head op`, `rsp_seq <= seq_cnt`, `rsp_valid <= 1`, head popped, `seq_cnt++`.
- Response drain: `rsp_valid && rsp_ready` with no issue clears `rsp_valid`. Drain plus issue in the same cycle keeps `rsp_valid = 1` with the new data.
- `seq_cnt` wraps modulo 2^SEQ_W.
- Read and write pointers are clog2(DEPTH) bits and wrap naturally. Occupancy is tracked by `fifo_count`.
- Simultaneous push and pop: `fifo_count` is unchanged. Order is strictly FIFO.
- Push when full is impossible because `req_ready = 0`. No pop ever occurs when empty.
- Requests are never dropped or reordered.

## Timing
- Reset (`rst_n` low, asynchronous):
  - FIFO is flushed; `fifo_count = 0`.
  - `seq_cnt = 0`.
  - `rsp_valid = 0`, `rsp_f = 0`, `rsp_op = 0`, `rsp_seq = 0`.
  - `alu_* = 0`.
  - `req_ready` reads 1; pushes are ignored while `rst_n` is low.
- Reset mid-operation discards all queued and registered results immediately. The first request after release gets seq 0.
- Latency: a request pushed at edge N appears on `alu_*` after edge N. Its result is in `rsp_f`, with `rsp_valid = 1`, after edge N+1, provided the response register is free. There is no empty-FIFO bypass.
- Throughput: one request per cycle sustained while `rsp_ready = 1`.
- The `alu_f` path is combinational through the external ALU and is sampled once per issue.

## Structure
- Package `alu_issue_pkg`:
  - `W`
  - `op_t` (2-bit)
  - `alu_req_t` struct {op, b, a}
- Sub-module `alu_req_fifo`: synchronous FIFO, parameterised by DEPTH and entry type, with push/pop/count/head outputs.
- The top level holds the issue logic, response register and sequence counter.
- `alu_4bit` is instantiated alongside this block by the parent, not inside it.

## Test plan
- **Reset:** hold `rst_n = 0` with `req_valid = 1` → `rsp_valid = 0`, `fifo_count = 0`, `alu_a = alu_b = 0`, `alu_op = 00`, `req_ready = 1`, nothing stored.
- **Single request:** `a = 2`, `b = 6`, `op = 00` pushed at edge 1 with `rsp_ready = 1` → after edge 1, `alu_a = 2`, `alu_b = 6`, `alu_op = 00`. After edge 2, `rsp_valid = 1`, `rsp_f` equals the ALU output for (2,6,00), `rsp_op = 00`, `rsp_seq = 0`, `fifo_count = 0`.
- **Backpressure/full:** `rsp_ready = 0`, push 6 back-to-back → after 5 accepts, the response register holds request 1, `fifo_count = 4`, `req_ready = 0`, and request 6 is held. Then set `rsp_ready = 1` → responses seq 0..5 appear in push order, one per cycle.
- **Simultaneous push/pop:** `fifo_count = 2`, push while an issue fires → `fifo_count` stays 2 and order is preserved.
- **Sequence wrap:** 17 consecutive requests → `rsp_seq` runs 0..15, then 0.
- **Mid-operation reset:** 3 entries queued and `rsp_valid = 1`, pulse `rst_n` low → all outputs reset immediately. The next request (`a = 2`, `b = 1`, `op = 01`) returns with `rsp_seq = 0`.
